netwalk_row_write_arbiter: RTL
==============================

Name: netwalk_row_write_arbiter

Overview:
- Shares the TCAM/netwalk row-write port among NUM_REQ independent requesters (table-update engine, CPU config port, etc.).
- Picks one requester with round-robin arbitration and latches that requester's row address and data.
- Drives row_addr into the existing one-hot row decoder and holds a write strobe for HOLD_CYCLES cycles.
- Returns a one-cycle ack to the winning requester.

Parameters:
- NUM_REQ, 4: number of requesters; must be at least 2.
- ADDR_WIDTH, 8: row address width; must equal the row decoder input width.
- DATA_WIDTH, 32: row write data width.
- HOLD_CYCLES, 2: number of cycles row_we stays high per write; must be at least 1.
- GRANT_W, derived as clog2(NUM_REQ): width of grant_id.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low.
- req  in  NUM_REQ  per-requester request level.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  packed in the same way.
- ack  out  NUM_REQ  one-hot, one-cycle completion pulse.
- row_addr  out  ADDR_WIDTH  row index to the decoder input.
- row_data  out  DATA_WIDTH  write data to the row array.
- row_we  out  1  row write strobe.
- grant_id  out  GRANT_W  index of the current or most recent winner.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset==0 at a clk edge):
  - FSM goes to IDLE.
  - All outputs go to 0.
  - The round-robin pointer ptr goes to 0.
  - Applies from any state, including mid-WRITE; the interrupted write gets no ack.
- FSM states: IDLE, WRITE, ACK.
- IDLE:
  - If req != 0, the winner is the first set bit searching upward from ptr, wrapping modulo NUM_REQ.
  - Latch the winner's req_addr/req_data into row_addr/row_data and set grant_id.
  - Load hold counter with HOLD_CYCLES; go to WRITE.
  - If req == 0, stay in IDLE; row_we=0 and ack=0.
- WRITE:
  - row_we=1; row_addr, row_data and grant_id stay stable.
  - Counter decrements each cycle; when counter==1, go to ACK on the next edge.
  - row_we is high for exactly HOLD_CYCLES cycles.
- ACK:
  - row_we=0 and ack[grant_id]=1 for one cycle.
  - ptr updates to (grant_id+1) mod NUM_REQ.
  - Next state is IDLE.
- Latency and throughput:
  - req seen in IDLE at cycle 0 → row_we high in cycles 1..HOLD_CYCLES → ack in cycle HOLD_CYCLES+1 → back in IDLE at HOLD_CYCLES+2.
  - Maximum throughput is one write per HOLD_CYCLES+2 cycles.
- Requester protocol:
  - Hold req, addr and data stable until ack is seen.
  - Deassert req at the edge that samples ack high, so IDLE sees the new req value.
  - A req still high in that IDLE cycle counts as a new request.
- Changes after capture:
  - req dropping or addr/data changing during WRITE/ACK is ignored; the latched values are written and ack is still issued.
- Fairness:
  - Round-robin means every persistently requesting requester is served within NUM_REQ grants.
  - Simultaneous requests are resolved purely by ptr order.
- Outputs between writes:
  - row_addr/row_data keep their last values in IDLE, so they are don't-care while row_we=0.
  - grant_id is valid whenever busy=1.
- Width and range:
  - No address range checking is done; the decoder covers the full 2^ADDR_WIDTH space.
  - The hold counter is clog2(HOLD_CYCLES+1) bits wide.

Decomposition:
- Shared package netwalk_pkg holds:
  - FSM state localparams (IDLE=2'd0, WRITE=2'd1, ACK=2'd2);
  - the clog2 function;
  - the default ADDR_WIDTH/DATA_WIDTH constants shared with the row decoder.
- One combinational sub-module, netwalk_rr_picker:
  - inputs: req[NUM_REQ], ptr[GRANT_W];
  - outputs: valid, winner index[GRANT_W];
  - implemented with a double-width rotate-and-priority search.
- The arbiter top holds the FSM, latches, counter and ptr.

Test Plan:
- Single request, defaults: req=4'b0001, addr0=8'h05, data0=32'hDEADBEEF at cycle 0 → row_we=1 with row_addr=8'h05 and row_data=32'hDEADBEEF in cycles 1–2; ack=4'b0001 in cycle 3; busy=0 in cycle 4.
- Fairness: req=4'b1111 held, with each requester dropping and then re-raising req after its ack → grant_id sequence is 0,1,2,3,0 with ack spacing of 4 cycles.
- Pointer wrap: after a grant to requester 2, apply req=4'b1011 → next grant is 3, then 0, then 1.
- Reset mid-operation: reset=0 during the first WRITE cycle → next cycle row_we=0, ack=0, busy=0, ptr=0 and no ack is ever issued for that write; then reset=1 with req=4'b1100 → grant_id=2.
- Request withdrawn: req[1] drops and addr1 changes during WRITE → the original address is still written for HOLD_CYCLES cycles and ack[1] pulses once.
- HOLD_CYCLES=1 build: single request → row_we high for exactly cycle 1, ack in cycle 2, IDLE in cycle 3.

Source files
------------

// File: rtl/netwalk_pkg.sv
// Shared constants for the netwalk row-write path: FSM encodings, row bus widths
// and a constant-foldable clog2 helper.
package netwalk_pkg;

    localparam int unsigned ROW_ADDR_WIDTH = 8;
    localparam int unsigned ROW_DATA_WIDTH = 32;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        for (int unsigned v = value - 1; v != 0; v = v >> 1) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/netwalk_rr_picker.sv
// Round-robin picker: first set request at or above ptr, wrapping modulo NUM_REQ.
module netwalk_rr_picker
    import netwalk_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned GRANT_W = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] ptr,
    output logic               valid_c,
    output logic [GRANT_W-1:0] winner_c
);

    localparam logic [GRANT_W:0] NUM_REQ_W = (GRANT_W+1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [GRANT_W-1:0]   off;
    logic [GRANT_W:0]     sum;

    // Rotate so ptr lands at bit 0, then take the lowest set bit as the offset.
    always_comb begin
        dbl = {req, req};
        rot = NUM_REQ'(dbl >> ptr);
        off = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = GRANT_W'(i);
            end
        end
        sum      = {1'b0, ptr} + {1'b0, off};
        winner_c = (sum >= NUM_REQ_W) ? GRANT_W'(sum - NUM_REQ_W) : GRANT_W'(sum);
        valid_c  = |req;
    end

endmodule

// File: rtl/netwalk_row_write_arbiter.sv
// Round-robin arbiter sharing the netwalk row-write port: latches the winner's
// row address/data, holds row_we for HOLD_CYCLES cycles, then pulses ack.
module netwalk_row_write_arbiter
    import netwalk_pkg::*;
#(
    parameter  int unsigned NUM_REQ     = 4,
    parameter  int unsigned ADDR_WIDTH  = ROW_ADDR_WIDTH,
    parameter  int unsigned DATA_WIDTH  = ROW_DATA_WIDTH,
    parameter  int unsigned HOLD_CYCLES = 2,
    localparam int unsigned GRANT_W     = clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [ADDR_WIDTH-1:0]         row_addr,
    output logic [DATA_WIDTH-1:0]         row_data,
    output logic                          row_we,
    output logic [GRANT_W-1:0]            grant_id,
    output logic                          busy
);

    localparam int unsigned      CNT_W    = clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [GRANT_W-1:0] LAST_ID = GRANT_W'(NUM_REQ - 1);

    logic [1:0]            state_q,    state_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [GRANT_W-1:0]    ptr_q,      ptr_d;
    logic [GRANT_W-1:0]    grant_q,    grant_d;
    logic [ADDR_WIDTH-1:0] row_addr_q, row_addr_d;
    logic [DATA_WIDTH-1:0] row_data_q, row_data_d;
    logic [NUM_REQ-1:0]    ack_q,      ack_d;
    logic                  row_we_q,   row_we_d;
    logic                  busy_q,     busy_d;

    logic                  pick_valid_c;
    logic [GRANT_W-1:0]    pick_id_c;

    netwalk_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req      (req),
        .ptr      (ptr_q),
        .valid_c  (pick_valid_c),
        .winner_c (pick_id_c)
    );

    // State and datapath registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            grant_q    <= '0;
            row_addr_q <= '0;
            row_data_q <= '0;
            ack_q      <= '0;
            row_we_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            row_addr_q <= row_addr_d;
            row_data_q <= row_data_d;
            ack_q      <= ack_d;
            row_we_q   <= row_we_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid_c) state_d = WRITE;
            WRITE:   if (cnt_q == CNT_ONE) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; outputs are registered from state_d.
    always_comb begin
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        row_addr_d = row_addr_q;
        row_data_d = row_data_q;
        ack_d      = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid_c) begin
                    grant_d    = pick_id_c;
                    row_addr_d = req_addr[32'(pick_id_c)*ADDR_WIDTH +: ADDR_WIDTH];
                    row_data_d = req_data[32'(pick_id_c)*DATA_WIDTH +: DATA_WIDTH];
                    cnt_d      = CNT_LOAD;
                end
            end
            WRITE: begin
                cnt_d = cnt_q - CNT_ONE;
            end
            ACK: begin
                ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + GRANT_W'(1);
            end
            default: begin
                cnt_d = '0;
            end
        endcase
        if (state_d == ACK) begin
            ack_d[grant_q] = 1'b1;
        end
        row_we_d = (state_d == WRITE);
        busy_d   = (state_d != IDLE);
    end

    assign ack      = ack_q;
    assign row_addr = row_addr_q;
    assign row_data = row_data_q;
    assign row_we   = row_we_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;

endmodule
